// File: rtl/sep_vc_allocator.sv
// Separable VC allocator: input-first round-robin, then per-downstream-VC round-robin; grants registered (1-cycle latency).
// Optional class restriction compiled in with `define VC_ALLOC_CLASS_EN.
module sep_vc_allocator #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int VC_TOTAL = 10,
  localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PORT_W  = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int IDX_W   = (VC_TOTAL > 1) ? $clog2(VC_TOTAL) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VC_TOTAL-1:0] idle_downstream_vc_i,
  input  logic [VC_TOTAL-1:0] vc_to_allocate_i,
  input  logic [PORT_W-1:0]   out_port_i [VC_TOTAL],
  output logic [VC_SIZE-1:0]  vc_new_o   [VC_TOTAL],
  output logic [VC_TOTAL-1:0] vc_valid_o
);

  if (VC_TOTAL != PORT_NUM * VC_NUM) begin : g_bad_total
    $error("sep_vc_allocator: VC_TOTAL must equal PORT_NUM*VC_NUM");
  end
`ifdef VC_ALLOC_CLASS_EN
  if ((VC_NUM % 2) != 0) begin : g_bad_class
    $error("sep_vc_allocator: VC_NUM must be even when classes are enabled");
  end
`endif

  logic [VC_TOTAL-1:0] vc_valid_q, vc_valid_d;
  logic [VC_SIZE-1:0]  vc_new_q [VC_TOTAL];
  logic [VC_SIZE-1:0]  vc_new_d [VC_TOTAL];
  logic [VC_SIZE-1:0]  p1_q [VC_TOTAL];
  logic [VC_SIZE-1:0]  p1_d [VC_TOTAL];
  logic [IDX_W-1:0]    p2_q [VC_TOTAL];
  logic [IDX_W-1:0]    p2_d [VC_TOTAL];
  logic [VC_TOTAL-1:0] reserved_q, reserved_d;

  logic [VC_TOTAL-1:0] avail, eff_req;
  logic [VC_NUM-1:0]   cand [VC_TOTAL];
  logic [VC_TOTAL-1:0] s1_vld;
  logic [VC_SIZE-1:0]  s1_v [VC_TOTAL];
  logic [IDX_W-1:0]    s1_d [VC_TOTAL];
  logic [VC_TOTAL-1:0] won, gnt;
  logic [IDX_W-1:0]    win_i [VC_TOTAL];

  assign avail   = idle_downstream_vc_i & ~reserved_q;
  assign eff_req = vc_to_allocate_i & ~vc_valid_q;

  // Candidate local VCs on each requester's routed port
  always_comb begin
    for (int i = 0; i < VC_TOTAL; i++) begin
      cand[i] = '0;
      for (int v = 0; v < VC_NUM; v++) begin
        if (int'(out_port_i[i]) < PORT_NUM) begin
          cand[i][v] = avail[int'(out_port_i[i]) * VC_NUM + v];
`ifdef VC_ALLOC_CLASS_EN
          if (((i % VC_NUM) >= VC_NUM / 2) != (v >= VC_NUM / 2)) begin
            cand[i][v] = 1'b0;
          end
`endif
        end
      end
    end
  end

  // Stage 1: each input VC picks one local VC starting at p1
  always_comb begin
    for (int i = 0; i < VC_TOTAL; i++) begin
      s1_vld[i] = 1'b0;
      s1_v[i]   = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        if (!s1_vld[i] && eff_req[i] && cand[i][(int'(p1_q[i]) + k) % VC_NUM]) begin
          s1_vld[i] = 1'b1;
          s1_v[i]   = VC_SIZE'((int'(p1_q[i]) + k) % VC_NUM);
        end
      end
      s1_d[i] = IDX_W'(int'(out_port_i[i]) * VC_NUM + int'(s1_v[i]));
    end
  end

  // Stage 2: each downstream VC picks one stage-1 requester starting at p2
  always_comb begin
    for (int d = 0; d < VC_TOTAL; d++) begin
      won[d]   = 1'b0;
      win_i[d] = '0;
      for (int k = 0; k < VC_TOTAL; k++) begin
        if (!won[d] && s1_vld[(int'(p2_q[d]) + k) % VC_TOTAL] &&
            int'(s1_d[(int'(p2_q[d]) + k) % VC_TOTAL]) == d) begin
          won[d]   = 1'b1;
          win_i[d] = IDX_W'((int'(p2_q[d]) + k) % VC_TOTAL);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < VC_TOTAL; i++) begin
      gnt[i] = 1'b0;
      for (int d = 0; d < VC_TOTAL; d++) begin
        if (won[d] && int'(win_i[d]) == i) begin
          gnt[i] = 1'b1;
        end
      end
    end
  end

  // Next state; a reservation drops once downstream reports the VC busy
  always_comb begin
    vc_valid_d = gnt;
    reserved_d = (reserved_q & idle_downstream_vc_i) | won;
    for (int i = 0; i < VC_TOTAL; i++) begin
      vc_new_d[i] = vc_new_q[i];
      p1_d[i]     = p1_q[i];
      p2_d[i]     = p2_q[i];
      if (gnt[i]) begin
        vc_new_d[i] = s1_v[i];
        p1_d[i]     = VC_SIZE'((int'(s1_v[i]) + 1) % VC_NUM);
      end
      if (won[i]) begin
        p2_d[i] = IDX_W'((int'(win_i[i]) + 1) % VC_TOTAL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vc_valid_q <= '0;
      reserved_q <= '0;
      for (int i = 0; i < VC_TOTAL; i++) begin
        vc_new_q[i] <= '0;
        p1_q[i]     <= '0;
        p2_q[i]     <= '0;
      end
    end else begin
      vc_valid_q <= vc_valid_d;
      reserved_q <= reserved_d;
      for (int i = 0; i < VC_TOTAL; i++) begin
        vc_new_q[i] <= vc_new_d[i];
        p1_q[i]     <= p1_d[i];
        p2_q[i]     <= p2_d[i];
      end
    end
  end

  assign vc_valid_o = vc_valid_q;
  assign vc_new_o   = vc_new_q;

endmodule

// File: tb/tb_sep_vc_allocator.sv
// Directed self-checking bench for sep_vc_allocator (default 5 ports x 2 VCs).
module tb_sep_vc_allocator;
  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_TOTAL = 10;
  localparam int VC_SIZE  = 1;

  logic                clk;
  logic                rst;
  logic [VC_TOTAL-1:0] idle;
  logic [VC_TOTAL-1:0] req;
  logic [2:0]          out_port [VC_TOTAL];
  logic [VC_SIZE-1:0]  vc_new   [VC_TOTAL];
  logic [VC_TOTAL-1:0] vc_valid;
  logic [VC_TOTAL*VC_SIZE-1:0] new_flat;

  int n_cmp = 0;
  int n_err = 0;

  sep_vc_allocator #(.PORT_NUM(PORT_NUM), .VC_NUM(VC_NUM), .VC_TOTAL(VC_TOTAL)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .idle_downstream_vc_i (idle),
    .vc_to_allocate_i     (req),
    .out_port_i           (out_port),
    .vc_new_o             (vc_new),
    .vc_valid_o           (vc_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < VC_TOTAL; i++) new_flat[i*VC_SIZE +: VC_SIZE] = vc_new[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idle = '1;
    req  = '0;
    for (int i = 0; i < VC_TOTAL; i++) out_port[i] = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      idle = VC_TOTAL'($urandom);
      req  = VC_TOTAL'($urandom);
      for (int i = 0; i < VC_TOTAL; i++) out_port[i] = 3'($urandom_range(0, 4));
      tick();
      n_cmp++;
      if (vc_valid !== 10'b0) begin n_err++; $display("FAIL reset_valid c%0d: got %b want 0", c, vc_valid); end
      n_cmp++;
      if (new_flat !== 10'b0) begin n_err++; $display("FAIL reset_new c%0d: got %b want 0", c, new_flat); end
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", vc_valid); end
    req[5] = 1'b1; out_port[5] = 3'd2;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0000100000) begin n_err++; $display("FAIL reset_first_grant: got %b want 0000100000", vc_valid); end
    n_cmp++;
    if (vc_new[5] !== 1'b0) begin n_err++; $display("FAIL reset_first_new: got %0d want 0", vc_new[5]); end
  endtask

  task automatic test_single();
    do_reset();
    req[0] = 1'b1; out_port[0] = 3'd1;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b1) begin n_err++; $display("FAIL single_valid1: got %b want 0000000001", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b0) begin n_err++; $display("FAIL single_new1: got %0d want 0", vc_new[0]); end
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0) begin n_err++; $display("FAIL single_pulse: got %b want 0", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b0) begin n_err++; $display("FAIL single_hold_new: got %0d want 0", vc_new[0]); end
    tick();
    n_cmp++;
    if (vc_valid !== 10'b1) begin n_err++; $display("FAIL single_valid2: got %b want 0000000001", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b1) begin n_err++; $display("FAIL single_new2: got %0d want 1", vc_new[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req[0] = 1'b1; out_port[0] = 3'd0;
    req[3] = 1'b1; out_port[3] = 3'd2;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0000001001) begin n_err++; $display("FAIL b2b_valid: got %b want 0000001001", vc_valid); end
    n_cmp++;
    if (vc_new[3] !== 1'b0) begin n_err++; $display("FAIL b2b_new3: got %0d want 0", vc_new[3]); end
  endtask

  task automatic test_contention();
    logic [VC_TOTAL-1:0] exp_v [3];
    exp_v[0] = 10'b0000000001;
    exp_v[1] = 10'b0000000100;
    exp_v[2] = 10'b0000010000;
    do_reset();
    idle = 10'b0000000100;
    for (int k = 0; k < 3; k++) begin req[2*k] = 1'b1; out_port[2*k] = 3'd1; end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (vc_valid !== exp_v[k]) begin n_err++; $display("FAIL cont_grant%0d: got %b want %b", k, vc_valid, exp_v[k]); end
      n_cmp++;
      if (vc_new[2*k] !== 1'b0) begin n_err++; $display("FAIL cont_new%0d: got %0d want 0", k, vc_new[2*k]); end
      req[2*k] = 1'b0;
      idle[2] = 1'b0;
      tick();
      n_cmp++;
      if (vc_valid !== 10'b0) begin n_err++; $display("FAIL cont_gap%0d: got %b want 0", k, vc_valid); end
      idle[2] = 1'b1;
    end
  endtask

  task automatic test_reservation();
    do_reset();
    idle = 10'b0000001000;
    req[0] = 1'b1; out_port[0] = 3'd1;
    req[2] = 1'b1; out_port[2] = 3'd1;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b1) begin n_err++; $display("FAIL resv_grant: got %b want 0000000001", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b1) begin n_err++; $display("FAIL resv_new0: got %0d want 1", vc_new[0]); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (vc_valid !== 10'b0) begin n_err++; $display("FAIL resv_block%0d: got %b want 0", c, vc_valid); end
    end
    idle[3] = 1'b0;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0) begin n_err++; $display("FAIL resv_busy: got %b want 0", vc_valid); end
    idle[3] = 1'b1;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0000000100) begin n_err++; $display("FAIL resv_regrant: got %b want 0000000100", vc_valid); end
    n_cmp++;
    if (vc_new[2] !== 1'b1) begin n_err++; $display("FAIL resv_new2: got %0d want 1", vc_new[2]); end
  endtask

  task automatic test_no_avail();
    do_reset();
    idle = 10'b0011111111;
    req  = '1;
    for (int i = 0; i < VC_TOTAL; i++) out_port[i] = 3'd4;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (vc_valid !== 10'b0) begin n_err++; $display("FAIL noav_quiet%0d: got %b want 0", c, vc_valid); end
    end
    idle[8] = 1'b1;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b1) begin n_err++; $display("FAIL noav_grant: got %b want 0000000001", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b0) begin n_err++; $display("FAIL noav_new: got %0d want 0", vc_new[0]); end
  endtask

  task automatic test_class();
    do_reset();
    idle = 10'b0000000001;
    req[1] = 1'b1; out_port[1] = 3'd0;
`ifdef VC_ALLOC_CLASS_EN
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (vc_valid !== 10'b0) begin n_err++; $display("FAIL class_block%0d: got %b want 0", c, vc_valid); end
    end
    idle = 10'b0000000010;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0000000010) begin n_err++; $display("FAIL class_grant: got %b want 0000000010", vc_valid); end
    n_cmp++;
    if (vc_new[1] !== 1'b1) begin n_err++; $display("FAIL class_new: got %0d want 1", vc_new[1]); end
`else
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0000000010) begin n_err++; $display("FAIL noclass_grant: got %b want 0000000010", vc_valid); end
    n_cmp++;
    if (vc_new[1] !== 1'b0) begin n_err++; $display("FAIL noclass_new: got %0d want 0", vc_new[1]); end
`endif
  endtask

  task automatic test_reset_midop();
    do_reset();
    req[0] = 1'b1; out_port[0] = 3'd1;
    tick();
    n_cmp++;
    if (vc_new[0] !== 1'b0 || vc_valid !== 10'b1) begin
      n_err++; $display("FAIL midrst_pre: got valid %b new %0d want 0000000001/0", vc_valid, vc_new[0]);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", vc_valid); end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (vc_valid !== 10'b1) begin n_err++; $display("FAIL midrst_regrant: got %b want 0000000001", vc_valid); end
    n_cmp++;
    if (vc_new[0] !== 1'b0) begin n_err++; $display("FAIL midrst_new: got %0d want 0", vc_new[0]); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_reservation();
    test_no_avail();
    test_class();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
